// File: rtl/route_vc_alloc.sv
// Single-input-port route computation and virtual-channel allocation stage.
// A header flit picks a direction and the lowest free VC; the packet then wormholes to that channel.
module route_vc_alloc #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int NUM_VC         = 2,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  parameter int ROUTING_MODE   = 0,
  parameter int ROUTING_HEADER = 0,
  localparam int CH            = 5 * NUM_VC,
  localparam int XW            = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
  localparam int YW            = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  input  logic [DATA_WIDTH-1:0]    in_tdata,
  input  logic [ID_WIDTH-1:0]      in_tid,
  input  logic                     in_tlast,
  input  logic [XW-1:0]            target_x,
  input  logic [YW-1:0]            target_y,
  input  logic [CH-1:0]            ext_busy,
  output logic [CH-1:0]            out_tvalid,
  input  logic [CH-1:0]            out_tready,
  output logic [CH*DATA_WIDTH-1:0] out_tdata,
  output logic [CH*ID_WIDTH-1:0]   out_tid,
  output logic [CH-1:0]            out_tlast,
  output logic [CH-1:0]            claim,
  output logic [15:0]              drop_cnt
);

  localparam int CHW = $clog2(CH);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;
  localparam logic [XW-1:0] RX = XW'(ROUTER_X);
  localparam logic [YW-1:0] RY = YW'(ROUTER_Y);
  localparam logic [ID_WIDTH-1:0] HDR_ID = ID_WIDTH'(ROUTING_HEADER);

  logic [0:0]     r_state;
  logic [CHW-1:0] r_route_ch;
  logic [CH-1:0]  r_claim;
  logic [15:0]    r_drop_cnt;

  logic [2:0]     w_dir;
  logic [CH-1:0]  w_taken;
  logic           w_free;
  logic [CHW-1:0] w_sel;
  logic           w_is_hdr;
  logic [CHW-1:0] w_out_ch;
  logic           w_fwd_en;
  logic           w_tready;
  logic           w_fwd;
  logic           w_hs;
  logic [CH-1:0]  w_hit;

  assign w_is_hdr = (in_tid == HDR_ID);
  assign w_taken  = r_claim | ext_busy;

  // Direction codes: 0 local, 1 north, 2 east, 3 south, 4 west.
  always_comb begin
    w_dir = 3'd0;
    if (ROUTING_MODE == 0) begin
      if (target_x > RX)      w_dir = 3'd2;
      else if (target_x < RX) w_dir = 3'd4;
      else if (target_y < RY) w_dir = 3'd1;
      else if (target_y > RY) w_dir = 3'd3;
    end else begin
      if (target_y < RY)      w_dir = 3'd1;
      else if (target_y > RY) w_dir = 3'd3;
      else if (target_x > RX) w_dir = 3'd2;
      else if (target_x < RX) w_dir = 3'd4;
    end
  end

  // Descending scan so the lowest free VC wins.
  always_comb begin
    w_free = 1'b0;
    w_sel  = '0;
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (!w_taken[int'(w_dir) * NUM_VC + v]) begin
        w_free = 1'b1;
        w_sel  = CHW'(int'(w_dir) * NUM_VC + v);
      end
    end
  end

  // Ready never looks at in_tvalid, so there is no loop back through the source.
  always_comb begin
    w_out_ch = r_route_ch;
    w_fwd_en = 1'b0;
    w_tready = 1'b1;
    if (r_state == S_ACTIVE) begin
      w_fwd_en = 1'b1;
      w_tready = out_tready[r_route_ch];
    end else if (w_is_hdr) begin
      if (w_free) begin
        w_out_ch = w_sel;
        w_fwd_en = 1'b1;
        w_tready = out_tready[w_sel];
      end else begin
        w_tready = 1'b0;
      end
    end
  end

  assign w_fwd     = in_tvalid & w_fwd_en;
  assign w_hs      = in_tvalid & w_tready;
  assign in_tready = w_tready;
  assign claim     = r_claim;
  assign drop_cnt  = r_drop_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      assign w_hit[gi]      = w_fwd && (w_out_ch == CHW'(gi));
      assign out_tvalid[gi] = w_hit[gi];
      assign out_tlast[gi]  = w_hit[gi] & in_tlast;
      assign out_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_hit[gi] ? in_tdata : '0;
      assign out_tid[gi*ID_WIDTH +: ID_WIDTH]       = w_hit[gi] ? in_tid : '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_route_ch <= '0;
      r_claim    <= '0;
      r_drop_cnt <= '0;
    end else if (w_hs) begin
      if (r_state == S_IDLE) begin
        if (w_is_hdr) begin
          // A single-flit packet passes through without holding the channel.
          r_route_ch <= w_sel;
          if (!in_tlast) begin
            r_claim[w_sel] <= 1'b1;
            r_state        <= S_ACTIVE;
          end
        end else if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (in_tlast) begin
        r_state             <= S_IDLE;
        r_claim[r_route_ch] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_route_vc_alloc.sv
// Randomized bench for route_vc_alloc: XY and YX instances at router (1,1) share stimulus
// and are compared every cycle against a packet-level reference model.
module tb_route_vc_alloc;

  localparam int CH = 10;
  localparam int DW = 32;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_tvalid;
  logic [DW-1:0]  in_tdata;
  logic [IW-1:0]  in_tid;
  logic           in_tlast;
  logic [1:0]     target_x;
  logic [1:0]     target_y;
  logic [CH-1:0]  ext_busy;
  logic [CH-1:0]  out_tready;

  logic           in_tready_v [2];
  logic [CH-1:0]  out_tvalid_v [2];
  logic [CH*DW-1:0] out_tdata_v [2];
  logic [CH*IW-1:0] out_tid_v [2];
  logic [CH-1:0]  out_tlast_v [2];
  logic [CH-1:0]  claim_v [2];
  logic [15:0]    drop_v [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: packet ownership per instance.
  int m_active [2];
  int m_route  [2];
  int m_drop   [2];
  bit m_claim  [2][CH];

  always #5 clk = ~clk;

  route_vc_alloc #(.ROUTER_X(1), .ROUTER_Y(1), .ROUTING_MODE(0)) u_xy (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready_v[0]), .in_tdata(in_tdata),
    .in_tid(in_tid), .in_tlast(in_tlast),
    .target_x(target_x), .target_y(target_y), .ext_busy(ext_busy),
    .out_tvalid(out_tvalid_v[0]), .out_tready(out_tready), .out_tdata(out_tdata_v[0]),
    .out_tid(out_tid_v[0]), .out_tlast(out_tlast_v[0]),
    .claim(claim_v[0]), .drop_cnt(drop_v[0])
  );

  route_vc_alloc #(.ROUTER_X(1), .ROUTER_Y(1), .ROUTING_MODE(1)) u_yx (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready_v[1]), .in_tdata(in_tdata),
    .in_tid(in_tid), .in_tlast(in_tlast),
    .target_x(target_x), .target_y(target_y), .ext_busy(ext_busy),
    .out_tvalid(out_tvalid_v[1]), .out_tready(out_tready), .out_tdata(out_tdata_v[1]),
    .out_tid(out_tid_v[1]), .out_tlast(out_tlast_v[1]),
    .claim(claim_v[1]), .drop_cnt(drop_v[1])
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_dir(input int mode, input int tx, input int ty);
    int xd, yd;
    xd = (tx > 1) ? 2 : (tx < 1) ? 4 : 0;
    yd = (ty < 1) ? 1 : (ty > 1) ? 3 : 0;
    if (mode == 0) return (xd != 0) ? xd : yd;
    return (yd != 0) ? yd : xd;
  endfunction

  task automatic model_eval(input int m, output bit tr, output int sel);
    int d;
    sel = -1;
    tr  = 1'b1;
    if (m_active[m] != 0) begin
      sel = m_route[m];
      tr  = out_tready[sel];
    end else if (in_tid == 4'd0) begin
      d = model_dir(m, int'(target_x), int'(target_y));
      for (int v = 0; v < 2; v++)
        if (sel < 0 && !m_claim[m][d*2+v] && !ext_busy[d*2+v]) sel = d*2 + v;
      tr = (sel >= 0) ? out_tready[sel] : 1'b0;
    end
  endtask

  function automatic logic [CH-1:0] model_claim_vec(input int m);
    logic [CH-1:0] cv;
    for (int c = 0; c < CH; c++) cv[c] = m_claim[m][c];
    return cv;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input bit quiet);
    bit tr [2];
    int sel [2];
    logic [CH-1:0]    ev;
    logic [CH*DW-1:0] ed;
    logic [CH*IW-1:0] ei;
    logic [CH-1:0]    el;
    for (int m = 0; m < 2; m++) model_eval(m, tr[m], sel[m]);
    #1;
    for (int m = 0; m < 2; m++) begin
      ev = '0; ed = '0; ei = '0; el = '0;
      if (in_tvalid && sel[m] >= 0) begin
        ev[sel[m]] = 1'b1;
        ed[sel[m]*DW +: DW] = in_tdata;
        ei[sel[m]*IW +: IW] = in_tid;
        el[sel[m]] = in_tlast;
      end
      if (in_tvalid) check_eq("in_tready", 512'(in_tready_v[m]), 512'(tr[m]));
      check_eq("out_tvalid", 512'(out_tvalid_v[m]), 512'(ev));
      check_eq("out_tdata", 512'(out_tdata_v[m]), 512'(ed));
      check_eq("out_tid", 512'(out_tid_v[m]), 512'(ei));
      check_eq("out_tlast", 512'(out_tlast_v[m]), 512'(el));
      check_eq("claim", 512'(claim_v[m]), 512'(model_claim_vec(m)));
      check_eq("drop_cnt", 512'(drop_v[m]), 512'(m_drop[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (in_tvalid && tr[m]) begin
        if (m_active[m] != 0) begin
          if (in_tlast) begin
            m_active[m] = 0;
            m_claim[m][m_route[m]] = 1'b0;
          end
        end else if (in_tid == 4'd0) begin
          if (!in_tlast) begin
            m_active[m] = 1;
            m_route[m] = sel[m];
            m_claim[m][sel[m]] = 1'b1;
          end
        end else if (m_drop[m] < 65535) begin
          m_drop[m]++;
        end
        if (!quiet)
          $display("t=%0t inst=%0d tid=%0h data=%08h last=%0b ch=%0d drops=%0d",
                   $time, m, in_tid, in_tdata, in_tlast, sel[m], m_drop[m]);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check_eq("rst_claim", 512'(claim_v[m]), 512'(0));
      check_eq("rst_drop", 512'(drop_v[m]), 512'(0));
      check_eq("rst_tvalid", 512'(out_tvalid_v[m]), 512'(0));
      m_active[m] = 0;
      m_route[m]  = 0;
      m_drop[m]   = 0;
      for (int c = 0; c < CH; c++) m_claim[m][c] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit v, input logic [3:0] tid, input bit last,
                       input int tx, input int ty, input logic [CH-1:0] busy);
    in_tvalid  = v;
    in_tid     = tid;
    in_tlast   = last;
    in_tdata   = $urandom;
    target_x   = 2'(tx);
    target_y   = 2'(ty);
    ext_busy   = busy;
    out_tready = '1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1, 1, '0);
    @(negedge clk);
    do_reset();

    // Header east from (1,1): XY takes east vc0, YX takes north vc0.
    drive(1'b1, 4'd0, 1'b0, 3, 0, '0);
    step(1'b0);
    check_eq("claim_xy_hdr", 512'(claim_v[0]), 512'(10'h010));
    check_eq("claim_yx_hdr", 512'(claim_v[1]), 512'(10'h004));
    drive(1'b1, 4'd5, 1'b0, 0, 3, '1);
    step(1'b0);
    // Reset mid-packet abandons it; the trailing body flit is dropped.
    do_reset();
    drive(1'b1, 4'd5, 1'b0, 3, 0, '0);
    step(1'b0);
    check_eq("drop_after_rst_xy", 512'(drop_v[0]), 512'(1));
    check_eq("drop_after_rst_yx", 512'(drop_v[1]), 512'(1));

    // Both east VCs held elsewhere: stall, then ch 4 as soon as it frees.
    do_reset();
    drive(1'b1, 4'd0, 1'b1, 3, 1, 10'h030);
    step(1'b0);
    check_eq("stall_tvalid", 512'(out_tvalid_v[0]), 512'(0));
    ext_busy = 10'h020;
    #1;
    check_eq("unstall_tvalid", 512'(out_tvalid_v[0]), 512'(10'h010));
    step(1'b0);

    // Randomized traffic with a reset dropped into the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      in_tvalid  = ($urandom_range(0, 3) != 0);
      in_tid     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      in_tlast   = ($urandom_range(0, 3) == 0);
      in_tdata   = $urandom;
      target_x   = 2'($urandom_range(0, 3));
      target_y   = 2'($urandom_range(0, 3));
      ext_busy   = 10'($urandom) & 10'($urandom);
      out_tready = ~(10'($urandom) & 10'($urandom) & 10'($urandom));
      step(1'b0);
    end

    // Drop counter saturation.
    do_reset();
    drive(1'b1, 4'd3, 1'b0, 2, 2, '0);
    for (int i = 0; i < 65540; i++) step(1'b1);
    check_eq("drop_sat_xy", 512'(drop_v[0]), 512'(16'hFFFF));
    check_eq("drop_sat_yx", 512'(drop_v[1]), 512'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/route_vc_alloc.md
ROUTE_VC_ALLOC -- requirements
Module: route_vc_alloc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI-Stream TDATA width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, TID width.
REQ-003 SHALL have parameter NUM_VC, default 2, virtual channels per direction (1..8).
REQ-004 SHALL have parameters MAX_ROUTERS_X / MAX_ROUTERS_Y, default 4 / 4, mesh size; coordinate widths = $clog2 of each.
REQ-005 SHALL have parameters ROUTER_X / ROUTER_Y, default 0 / 0, this router's coordinates.
REQ-006 SHALL have parameter ROUTING_MODE, default 0, 0 = XY dimension order, 1 = YX.
REQ-007 SHALL have parameter ROUTING_HEADER, default 0, TID value marking a header flit.
REQ-008 SHALL derive localparam CH = 5*NUM_VC; channel index = dir*NUM_VC + vc; dir 0 local, 1 north (target_y < ROUTER_Y), 2 east (target_x > ROUTER_X), 3 south (target_y > ROUTER_Y), 4 west (target_x < ROUTER_X).
REQ-009 SHALL have ports clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-010 SHALL have ports in_tvalid  in  1; in_tready  out  1; in_tdata  in  DATA_WIDTH; in_tid  in  ID_WIDTH; in_tlast  in  1  (input stream).
REQ-011 SHALL have ports target_x  in  X width; target_y  in  Y width  (destination, sampled with header flit only).
REQ-012 SHALL have port ext_busy  in  CH  channels held by other input ports.
REQ-013 SHALL have ports out_tvalid  out  CH; out_tready  in  CH; out_tdata  out  CH*DATA_WIDTH; out_tid  out  CH*ID_WIDTH; out_tlast  out  CH  (channel c at slice c).
REQ-014 SHALL have ports claim  out  CH  channels owned by this instance (registered); drop_cnt  out  16  discarded-flit count.

Function
REQ-015 SHALL implement FSM states IDLE and ACTIVE plus registered route_ch (CH index width).
REQ-016 Direction (IDLE, header valid): XY mode -> east/west while target_x differs, else north/south, else local; YX mode -> north/south while target_y differs, else east/west, else local.
REQ-017 Free VC = lowest vc with !(claim|ext_busy)[dir*NUM_VC+vc].
REQ-018 IDLE, header valid, free VC exists: drive selected channel combinationally with in_* fields, out_tvalid=1; in_tready = out_tready[selected].
REQ-019 IDLE, header valid, no free VC: in_tready=0, all out_tvalid=0; retried every cycle, no latency penalty once a VC frees.
REQ-020 IDLE header handshake: route_ch <= selected; claim[selected] <= 1; state <= ACTIVE, unless in_tlast=1 (single-flit packet) -> stay IDLE, claim unchanged.
REQ-021 ACTIVE: every flit (header TID included) forwarded to route_ch; target_x/target_y and ext_busy ignored; in_tready = out_tready[route_ch].
REQ-022 ACTIVE handshake with in_tlast=1: state <= IDLE, claim[route_ch] <= 0 same edge; a new header may be accepted the next cycle.
REQ-023 IDLE, non-header flit valid: discard -- in_tready=1, no out_tvalid, drop_cnt += 1 saturating at 16'hFFFF.
REQ-024 Non-selected channels SHALL drive tvalid/tdata/tid/tlast = 0; in_tready = 0 when in_tvalid = 0 is permitted only if it does not depend on state (in_tready = out_tready[route_ch] in ACTIVE, 1 in IDLE).
REQ-025 in_tready SHALL depend only on registered state, ext_busy, target and out_tready -- no combinational loop through in_tvalid.
REQ-026 Forwarding latency 0 cycles (combinational path); claim visible 1 cycle after header handshake.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, route_ch=0, claim=0, drop_cnt=0; outputs derived from these (all out_tvalid=0 when in_tvalid=0).
REQ-028 Reset mid-packet SHALL abandon the packet; remaining body flits after release are dropped per REQ-023.

Verification
REQ-029 ROUTER(1,1), XY, NUM_VC=2: header target(3,0), out_tready all 1 -> out ch 4 (east vc0) valid, claim=0x010 next cycle; 3 body flits + tlast -> claim=0 after last.
REQ-030 Same, YX mode, target(3,0) -> ch 2 (north vc0); target(1,1) -> ch 0 local.
REQ-031 ext_busy=0x010, header east -> ch 5 selected; ext_busy=0x030 -> in_tready=0, no out_tvalid until ext_busy[4] clears, then ch 4 same cycle.
REQ-032 Body flit (TID!=0) in IDLE x3 -> in_tready=1, no outputs, drop_cnt=3; 70000 drops -> drop_cnt=65535.
REQ-033 ACTIVE on ch 4, out_tready[4]=0 for 5 cycles -> in_tready=0, data held stable; target changes mid-packet -> route unchanged.
REQ-034 rst_n pulsed low mid-packet -> claim=0, state IDLE immediately; next body flit dropped, drop_cnt=1.
